hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: tracks the E/M/W slots, selects execute-operand
// forwarding, and raises load-use / multi-cycle stalls and taken-branch flushes.
module hazard_fwd_sel (
    input  logic [4:0] src,
    input  logic       m_valid,
    input  logic       m_regwrite,
    input  logic       m_load,
    input  logic [4:0] m_rd,
    input  logic       w_valid,
    input  logic       w_regwrite,
    input  logic [4:0] w_rd,
    output logic [1:0] sel
);
    logic m_hit, w_hit;

    // A load in M has no data yet; the load-use stall keeps that path dead.
    assign m_hit = m_valid && m_regwrite && (m_rd != 5'd0) && (m_rd == src) && !m_load;
    assign w_hit = w_valid && w_regwrite && (w_rd != 5'd0) && (w_rd == src);
    assign sel   = m_hit ? 2'd2 : (w_hit ? 2'd1 : 2'd0);
endmodule

module hazard_ctrl #(
    parameter int MC_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_valid,
    input  logic [4:0] d_rs1,
    input  logic [4:0] d_rs2,
    input  logic [4:0] d_rd,
    input  logic       d_regwrite,
    input  logic       d_load,
    input  logic       d_mc,
    input  logic       PCSrc,
    output logic [1:0] R_1_solve,
    output logic [1:0] R_2_solve,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE
);
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       load;
        logic       mc;
    } e_slot_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       load;
    } m_slot_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
    } w_slot_t;

    localparam logic [3:0] MC_LOAD = 4'(MC_CYCLES - 1);

    e_slot_t         e_q, d_slot;
    m_slot_t         m_q;
    w_slot_t         w_q;
    logic [1:0][4:0] e_src_q, d_src;
    logic [1:0][1:0] fwd_sel;
    logic [3:0]      busy_cnt;
    logic            busy, branch, load_use, e_hits_d;

    assign d_src  = {d_rs2, d_rs1};
    assign d_slot = '{valid: d_valid, rd: d_rd, regwrite: d_regwrite, load: d_load, mc: d_mc};
    assign busy   = e_q.mc && (busy_cnt != 4'd0);
    assign branch = PCSrc && !busy;

    always_comb begin
        e_hits_d = 1'b0;
        for (int i = 0; i < 2; i++)
            if (e_q.valid && e_q.regwrite && (e_q.rd != 5'd0) && (e_q.rd == d_src[i]))
                e_hits_d = 1'b1;
    end

    // Busy wins over branch, branch wins over load-use.
    assign load_use = !busy && !branch && d_valid && e_q.load && e_hits_d;

    for (genvar i = 0; i < 2; i++) begin : g_fwd
        hazard_fwd_sel u_sel (
            .src        (e_src_q[i]),
            .m_valid    (m_q.valid),
            .m_regwrite (m_q.regwrite),
            .m_load     (m_q.load),
            .m_rd       (m_q.rd),
            .w_valid    (w_q.valid),
            .w_regwrite (w_q.regwrite),
            .w_rd       (w_q.rd),
            .sel        (fwd_sel[i])
        );
    end

    always_comb begin
        R_1_solve = 2'd0;
        R_2_solve = 2'd0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        if (!reset) begin
            R_1_solve = fwd_sel[0];
            R_2_solve = fwd_sel[1];
            StallF    = busy || load_use;
            StallD    = busy || load_use;
            StallE    = busy;
            FlushD    = branch;
            FlushE    = branch || load_use;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q      <= '0;
            m_q      <= '0;
            w_q      <= '0;
            e_src_q  <= '0;
            busy_cnt <= '0;
        end else if (busy) begin
            busy_cnt <= busy_cnt - 4'd1;
            m_q      <= '0;
            w_q      <= '{m_q.valid, m_q.rd, m_q.regwrite};
        end else begin
            w_q <= '{m_q.valid, m_q.rd, m_q.regwrite};
            m_q <= '{e_q.valid, e_q.rd, e_q.regwrite, e_q.load};
            if (d_valid && !branch && !load_use) begin
                e_q      <= d_slot;
                e_src_q  <= d_src;
                busy_cnt <= d_mc ? MC_LOAD : 4'd0;
            end else begin
                e_q     <= '0;
                e_src_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios plus random
// instruction streams checked against an instruction-level pipeline model.
module tb_hazard_ctrl;
    localparam int MC = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       d_valid = 1'b0, d_regwrite = 1'b0, d_load = 1'b0, d_mc = 1'b0, PCSrc = 1'b0;
    logic [4:0] d_rs1 = '0, d_rs2 = '0, d_rd = '0;
    logic [1:0] R_1_solve, R_2_solve;
    logic       StallF, StallD, StallE, FlushD, FlushE;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.MC_CYCLES(MC)) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
        .d_rd(d_rd), .d_regwrite(d_regwrite), .d_load(d_load), .d_mc(d_mc), .PCSrc(PCSrc),
        .R_1_solve(R_1_solve), .R_2_solve(R_2_solve), .StallF(StallF), .StallD(StallD),
        .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] r1, r2;
        logic       sf, sd, se, fd, fe;
    } out_t;

    out_t act;
    assign act = {R_1_solve, R_2_solve, StallF, StallD, StallE, FlushD, FlushE};

    // Model: whole instructions sitting in E/M/W, plus how long E's has stayed there.
    typedef struct {
        bit       valid;
        bit [4:0] rd, rs1, rs2;
        bit       rw, ld, mc;
    } ins_t;

    ins_t mE, mM, mW;
    int   age = 0;

    function automatic bit m_hit(ins_t s, logic [4:0] r);
        return s.valid && s.rw && s.rd != 5'd0 && s.rd == r;
    endfunction

    function automatic logic [1:0] m_fsel(logic [4:0] r);
        if (!mE.valid) return 2'd0;
        if (m_hit(mM, r) && !mM.ld) return 2'd2;
        if (m_hit(mW, r)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic void m_flags(output bit b, output bit br, output bit lu);
        b  = mE.valid && mE.mc && (age < MC - 1);
        br = PCSrc && !b;
        lu = !b && !br && d_valid && mE.valid && mE.ld &&
             (m_hit(mE, d_rs1) || m_hit(mE, d_rs2));
    endfunction

    function automatic out_t model_out();
        out_t o = '0;
        bit b, br, lu;
        if (reset) return o;
        m_flags(b, br, lu);
        o.r1 = m_fsel(mE.rs1);
        o.r2 = m_fsel(mE.rs2);
        o.sf = b || lu;
        o.sd = b || lu;
        o.se = b;
        o.fd = br;
        o.fe = br || lu;
        return o;
    endfunction

    function automatic void model_adv();
        bit b, br, lu;
        if (reset) begin
            mE = '{default: 0}; mM = mE; mW = mE; age = 0;
            return;
        end
        m_flags(b, br, lu);
        mW = mM;
        if (b) begin
            mM = '{default: 0};
            age++;
        end else begin
            mM  = mE;
            age = 0;
            if (d_valid && !br && !lu)
                mE = '{valid: 1, rd: d_rd, rs1: d_rs1, rs2: d_rs2, rw: d_regwrite, ld: d_load, mc: d_mc};
            else
                mE = '{default: 0};
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_adv();
        #1;
    endtask

    task automatic drv(bit v, int rs1, int rs2, int rd, bit rw, bit ld, bit mc, bit pc);
        d_valid = v; d_rs1 = 5'(rs1); d_rs2 = 5'(rs2); d_rd = 5'(rd);
        d_regwrite = rw; d_load = ld; d_mc = mc; PCSrc = pc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drv(1, 3, 3, 3, 1, 1, i[0], 1);
            @(negedge clk);
            total++;
            if (act !== '0) begin
                bad++; $display("FAIL reset_outs cyc%0d got=%b want=%b", i, act, 9'b0);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_forward();
        out_t e;
        for (int i = 0; i < 11; i++) begin
            case (i)
                0:       drv(1, 1, 2, 5, 1, 0, 0, 0);  // ADD x5
                1:       drv(1, 5, 5, 6, 1, 0, 0, 0);  // ADD x6,x5,x5
                3:       drv(1, 1, 2, 5, 1, 0, 0, 0);  // ADD x5
                5:       drv(1, 5, 0, 7, 1, 0, 0, 0);  // SUB x7,x5,x0
                7:       drv(1, 1, 2, 9, 1, 0, 0, 0);  // ADD x9
                8:       drv(1, 3, 4, 9, 1, 0, 0, 0);  // ADD x9 again
                9:       drv(1, 9, 0, 10, 1, 0, 0, 0); // ADD x10,x9,x0
                default: drv(0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            @(negedge clk);
            e = model_out();
            total++;
            if (act !== e) begin
                bad++; $display("FAIL fwd_model cyc%0d got=%b want=%b", i, act, e);
            end
            if (i == 2) begin
                total++;
                if ({act.r1, act.r2, act.sf, act.sd, act.se} !== 7'b1010000) begin
                    bad++; $display("FAIL fwd_mem_both cyc%0d got=%b want=%b", i,
                                    {act.r1, act.r2, act.sf, act.sd, act.se}, 7'b1010000);
                end
            end
            if (i == 6) begin
                total++;
                if ({act.r1, act.r2} !== 4'b0100) begin
                    bad++; $display("FAIL fwd_wb_x0 got=%b want=%b", {act.r1, act.r2}, 4'b0100);
                end
            end
            if (i == 10) begin
                total++;
                if (act.r1 !== 2'd2) begin
                    bad++; $display("FAIL fwd_m_priority got=%0d want=2", act.r1);
                end
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        out_t e;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       drv(1, 1, 0, 3, 1, 1, 0, 0);  // LW x3
                1, 2:    drv(1, 3, 1, 4, 1, 0, 0, 0);  // ADD x4,x3,x1 (held while stalled)
                default: drv(0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            @(negedge clk);
            e = model_out();
            total++;
            if (act !== e) begin
                bad++; $display("FAIL lu_model cyc%0d got=%b want=%b", i, act, e);
            end
            if (i == 1 || i == 2) begin
                total++;
                if ({act.sf, act.sd, act.se, act.fd, act.fe} !== ((i == 1) ? 5'b11001 : 5'b00000)) begin
                    bad++; $display("FAIL lu_stall cyc%0d got=%b want=%b", i,
                                    {act.sf, act.sd, act.se, act.fd, act.fe},
                                    (i == 1) ? 5'b11001 : 5'b00000);
                end
            end
            if (i == 3) begin
                total++;
                if (act.r1 !== 2'd1) begin
                    bad++; $display("FAIL lu_fwd_wb got=%0d want=1", act.r1);
                end
            end
            tick();
        end
    endtask

    task automatic test_multicycle();
        out_t e;
        bit   hold = 0;
        int   n_se = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 0)      drv(1, 1, 2, 8, 1, 0, 1, 0);      // MUL x8
            else if (i == 1) drv(1, 8, 2, 9, 1, 0, 1, 0);      // MUL x9 back-to-back
            else if (!hold)  drv(0, 0, 0, 0, 0, 0, 0, 0);
            PCSrc = (i == 2);
            @(negedge clk);
            e = model_out();
            total++;
            if (act !== e) begin
                bad++; $display("FAIL mc_model cyc%0d got=%b want=%b", i, act, e);
            end
            if (i == 2) begin
                total++;
                if ({act.se, act.fd, act.fe} !== 3'b100) begin
                    bad++; $display("FAIL mc_pcsrc_ignored got=%b want=100", {act.se, act.fd, act.fe});
                end
            end
            n_se += int'(act.se);
            hold = e.sd;
            tick();
        end
        total++;
        if (n_se != 2 * (MC - 1)) begin
            bad++; $display("FAIL mc_stall_cycles got=%0d want=%0d", n_se, 2 * (MC - 1));
        end
    endtask

    task automatic test_branch_reset();
        out_t e;
        for (int i = 0; i < 7; i++) begin
            case (i)
                0:       drv(1, 1, 0, 3, 1, 1, 0, 0);  // LW x3
                1:       drv(1, 3, 1, 4, 1, 0, 0, 1);  // dependent ADD with taken branch
                2:       drv(1, 1, 2, 8, 1, 0, 1, 0);  // MUL x8
                default: drv(0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            reset = (i == 4);
            @(negedge clk);
            e = model_out();
            total++;
            if (act !== e) begin
                bad++; $display("FAIL br_model cyc%0d got=%b want=%b", i, act, e);
            end
            if (i == 1) begin
                total++;
                if ({act.sf, act.sd, act.se, act.fd, act.fe} !== 5'b00011) begin
                    bad++; $display("FAIL br_over_lu got=%b want=00011", {act.sf, act.sd, act.se, act.fd, act.fe});
                end
            end
            if (i == 4) begin
                total++;
                if (act !== '0) begin
                    bad++; $display("FAIL reset_mid_busy got=%b want=%b", act, 9'b0);
                end
            end
            if (i == 5) begin
                total++;
                if ({act.sf, act.sd, act.se, act.fd, act.fe} !== 5'b00000) begin
                    bad++; $display("FAIL after_reset_stall got=%b want=00000", {act.sf, act.sd, act.se, act.fd, act.fe});
                end
            end
            tick();
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        out_t e;
        bit   hold = 0;
        bit   ld, mc;
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            if (!hold) begin
                if ($urandom_range(0, 3) != 0) begin
                    ld = ($urandom_range(0, 4) == 0);
                    mc = !ld && ($urandom_range(0, 9) == 0);
                    drv(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                        ld || ($urandom_range(0, 3) != 0), ld, mc, 0);
                end else begin
                    drv(0, 0, 0, 0, 0, 0, 0, 0);
                end
            end
            PCSrc = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            e = model_out();
            total++;
            if (act !== e) begin
                bad++; $display("FAIL rand_model cyc%0d got=%b want=%b", i, act, e);
            end
            hold = e.sd;
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_multicycle();
        test_branch_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
